multicycle_datapath: RTL and testbench

Parametrised multicycle MIPS datapath that succeeds the single-cycle datapath. It uses one unified memory port, with instructions and data sharing `Adr`/`ReadData`, and holds state in architectural and non-architectural registers (PC, IR, Data, A, B, ALUOut). Each instruction executes over several clock cycles under an external multicycle controller. Additions over the single-cycle datapath:

- memory stall input
- `bne` support
- `jr` (register-indirect PC)
- configurable reset vector
- configurable register-file depth
- optional hardwired r0

---
 rtl/multicycle_datapath.sv | 129 ++++++++++++
 tb/tb_multicycle_datapath.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath with one unified memory port and a stall input.
// State: PC, IR, Data, A, B, ALUOut and the GPR file, all frozen while MemStall is high.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemStall,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        BranchNE,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ALUControl,
  input  logic [1:0]  PCSrc,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] ReadData,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic [31:0] Instr,
  output logic        Zero
);

  logic [31:0] pc_q, ir_q, data_q, a_q, b_q, aluout_q;
  logic [31:0] pc_d, ir_d;
  logic [31:0] rf_q [NUM_REGS];
  logic [NUM_REGS-1:0] rf_we;

  logic [31:0] sign_imm, jump_target, src_a, src_b, alu_result, pc_target, result;
  logic [31:0] rd1, rd2;
  logic [4:0]  write_reg;
  logic        pc_en;

  assign sign_imm    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign write_reg   = RegDst ? ir_q[15:11] : ir_q[20:16];
  assign result      = MemtoReg ? data_q : aluout_q;

  // Unimplemented indices fall through to 0; r0 is forced to 0 when hardwired.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ir_q[25:21] == 5'(i)) rd1 = rf_q[i];
      if (ir_q[20:16] == 5'(i)) rd2 = rf_q[i];
    end
    if (ZERO_REG && ir_q[25:21] == 5'd0) rd1 = '0;
    if (ZERO_REG && ir_q[20:16] == 5'd0) rd2 = '0;
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf_we
      assign rf_we[gi] = RegWrite && (write_reg == 5'(gi)) && !(ZERO_REG && gi == 0);
    end
  endgenerate

  assign src_a = ALUSrcA ? a_q : pc_q;

  always_comb begin
    src_b = b_q;
    case (ALUSrcB)
      2'b00:   src_b = b_q;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = sign_imm;
      default: src_b = {sign_imm[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      3'b010:  alu_result = src_a + src_b;
      3'b110:  alu_result = src_a - src_b;
      3'b000:  alu_result = src_a & src_b;
      3'b001:  alu_result = src_a | src_b;
      3'b111:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == 32'd0);

  always_comb begin
    pc_target = alu_result;
    case (PCSrc)
      2'b00:   pc_target = alu_result;
      2'b01:   pc_target = aluout_q;
      2'b10:   pc_target = jump_target;
      default: pc_target = a_q;
    endcase
  end

  assign pc_en = PCWrite | (Branch & Zero) | (BranchNE & ~Zero);
  assign pc_d  = pc_en ? pc_target : pc_q;
  assign ir_d  = IRWrite ? ReadData : ir_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      data_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (!MemStall) begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      data_q   <= ReadData;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= alu_result;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rf_we[i]) rf_q[i] <= result;
      end
    end
  end

  assign Adr       = IorD ? aluout_q : pc_q;
  assign WriteData = b_q;
  assign Instr     = ir_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath (RESET_PC=0x40, 16 GPRs, hardwired r0).
// Directed vectors and sequences plus a randomized register/ALU run against a simple model.
module tb_multicycle_datapath;

  localparam logic [31:0] RPC = 32'h40;

  logic        clk = 1'b0;
  logic        reset, mem_stall, iord, irwrite, pcwrite, branch, branchne, alusrca;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  aluctl;
  logic        regdst, memtoreg, regwrite;
  logic [31:0] read_data, adr, write_data, instr;
  logic        zero;

  multicycle_datapath #(.RESET_PC(RPC), .NUM_REGS(16), .ZERO_REG(1'b1)) dut (
    .CLK(clk), .Reset(reset), .MemStall(mem_stall), .IorD(iord), .IRWrite(irwrite),
    .PCWrite(pcwrite), .Branch(branch), .BranchNE(branchne), .ALUSrcA(alusrca),
    .ALUSrcB(alusrcb), .ALUControl(aluctl), .PCSrc(pcsrc), .RegDst(regdst),
    .MemtoReg(memtoreg), .RegWrite(regwrite), .ReadData(read_data), .Adr(adr),
    .WriteData(write_data), .Instr(instr), .Zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t    vecs [12];
  logic [31:0] model_rf [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Architectural view: only r1..r15 hold data, everything else reads 0.
  function automatic void model_write(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0 && r < 5'd16) model_rf[r] = v;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic idle();
    iord = 0; irwrite = 0; pcwrite = 0; branch = 0; branchne = 0; alusrca = 0;
    alusrcb = 2'b00; aluctl = 3'b000; pcsrc = 2'b00; regdst = 0; memtoreg = 0;
    regwrite = 0; mem_stall = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    idle();
    irwrite = 1; read_data = v;
    tick();
    irwrite = 0;
  endtask

  // Writes through Data -> Result path; optionally stalls the write edge so nothing lands.
  task automatic write_reg(input logic [4:0] r, input logic [31:0] v, input bit stalled);
    load_ir({6'h23, 5'd0, r, 16'h0});
    read_data = v;
    tick();
    regwrite = 1; memtoreg = 1; mem_stall = stalled;
    tick();
    idle();
    if (!stalled) model_write(r, v);
  endtask

  task automatic read_regs(input logic [4:0] rs, input logic [4:0] rt,
                           output logic [31:0] av, output logic [31:0] bv);
    load_ir({6'h0, rs, rt, 16'h0});
    tick();
    bv = write_data;
    alusrca = 1; alusrcb = 2'b10; aluctl = 3'b010;
    tick();
    iord = 1;
    #1;
    av = adr;
    idle();
  endtask

  task automatic alu_check(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [2:0] op, input logic [31:0] exp);
    load_ir({6'h0, rs, rt, 16'h0});
    tick();
    alusrca = 1; alusrcb = 2'b00; aluctl = op;
    #1;
    check($sformatf("%s zero", nm), {31'b0, zero}, {31'b0, exp == 32'd0});
    tick();
    iord = 1;
    #1;
    check($sformatf("%s result", nm), adr, exp);
    idle();
  endtask

  task automatic do_branch(input string nm, input logic [31:0] bval, input logic [31:0] target,
                           input bit beq, input bit bneq, input logic [31:0] exp_pc);
    write_reg(5'd1, 32'd5, 1'b0);
    write_reg(5'd2, bval, 1'b0);
    load_ir({6'h4, 5'd1, 5'd2, 16'(target - 32'd5)});
    tick();
    alusrca = 1; alusrcb = 2'b10; aluctl = 3'b010;
    tick();
    alusrcb = 2'b00; aluctl = 3'b110; pcsrc = 2'b01; branch = beq; branchne = bneq;
    #1;
    check($sformatf("%s zero", nm), {31'b0, zero}, {31'b0, bval == 32'd5});
    tick();
    idle();
    #1;
    check($sformatf("%s pc", nm), adr, exp_pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] av, bv;
    logic [4:0]  r, rs, rt;
    logic [31:0] v;
    logic [2:0]  op;

    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    vecs[0]  = '{3'b010, 32'd5,         32'd7,         32'd12};
    vecs[1]  = '{3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[2]  = '{3'b110, 32'd5,         32'd5,         32'd0};
    vecs[3]  = '{3'b110, 32'd3,         32'd5,         32'hFFFF_FFFE};
    vecs[4]  = '{3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vecs[5]  = '{3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
    vecs[6]  = '{3'b111, 32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[7]  = '{3'b111, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vecs[8]  = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[9]  = '{3'b011, 32'd9,         32'd9,         32'd0};
    vecs[10] = '{3'b100, 32'hFFFF_FFFF, 32'h1,         32'd0};
    vecs[11] = '{3'b101, 32'h1234,      32'h5678,      32'd0};

    idle();
    read_data = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    write_reg(5'd5, 32'h55, 1'b0);
    read_regs(5'd5, 5'd5, av, bv);
    check("pre-reset r5", bv, 32'h55);

    // Reset with random controls and MemStall high; reset must win.
    reset = 1; mem_stall = 1;
    {iord, irwrite, pcwrite, branch, branchne, alusrca, alusrcb, aluctl, pcsrc,
     regdst, memtoreg, regwrite} = 16'($urandom);
    read_data = $urandom;
    tick(); tick();
    idle();
    #1;
    check("reset adr", adr, RPC);
    check("reset instr", instr, 32'h0);
    check("reset writedata", write_data, 32'h0);
    aluctl = 3'b000;
    #1;
    check("reset zero and", {31'b0, zero}, 32'd1);
    aluctl = 3'b010;
    #1;
    check("reset zero add", {31'b0, zero}, 32'd0);
    reset = 0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;

    // Fetch held off by stall, then completes in one edge.
    idle();
    irwrite = 1; alusrcb = 2'b01; aluctl = 3'b010; pcwrite = 1;
    read_data = 32'h8C0A_0004; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d pc", i), adr, RPC);
      check($sformatf("stall%0d ir", i), instr, 32'h0);
    end
    mem_stall = 0;
    tick();
    check("fetch ir", instr, 32'h8C0A_0004);
    check("fetch pc", adr, 32'h44);
    idle();

    read_regs(5'd5, 5'd5, av, bv);
    check("post-reset r5", bv, 32'h0);

    // lw $10, 4($8)
    for (int i = 0; i < 10; i++)
      write_reg(5'(i), (i == 8) ? 32'h100 : 32'(i * 32'h11), 1'b0);
    load_ir(32'h8D0A_0004);
    tick();
    alusrca = 1; alusrcb = 2'b10; aluctl = 3'b010;
    tick();
    idle();
    iord = 1;
    #1;
    check("lw memadr", adr, 32'h104);
    read_data = 32'hDEAD_BEEF;
    tick();
    idle();
    memtoreg = 1; regwrite = 1;
    tick();
    idle();
    model_write(5'd10, 32'hDEAD_BEEF);
    read_regs(5'd8, 5'd10, av, bv);
    check("lw base r8", av, 32'h100);
    check("lw r10", bv, 32'hDEAD_BEEF);
    #1;
    check("lw pc kept", adr, 32'h44);

    for (int i = 0; i < 12; i++) begin
      write_reg(5'd1, vecs[i].a, 1'b0);
      write_reg(5'd2, vecs[i].b, 1'b0);
      alu_check($sformatf("vec%0d op%b", i, vecs[i].op), 5'd1, 5'd2, vecs[i].op, vecs[i].exp);
    end

    do_branch("bne equal", 32'd5, 32'h80, 1'b0, 1'b1, 32'h44);
    do_branch("beq equal", 32'd5, 32'h80, 1'b1, 1'b0, 32'h80);
    do_branch("bne differ", 32'd6, 32'hC0, 1'b0, 1'b1, 32'hC0);
    do_branch("beq differ", 32'd6, 32'h100, 1'b1, 1'b0, 32'hC0);

    // jr to 0x1000_0044, then j, then jr again.
    write_reg(5'd3, 32'h1000_0044, 1'b0);
    load_ir({6'h0, 5'd3, 5'd0, 16'h0008});
    tick();
    pcsrc = 2'b11; pcwrite = 1;
    tick(); idle(); #1;
    check("jr pc", adr, 32'h1000_0044);
    load_ir(32'h0800_0010);
    pcsrc = 2'b10; pcwrite = 1;
    tick(); idle(); #1;
    check("j pc", adr, 32'h1000_0040);
    write_reg(5'd4, 32'h200, 1'b0);
    load_ir({6'h0, 5'd4, 5'd0, 16'h0008});
    tick();
    pcsrc = 2'b11; pcwrite = 1;
    tick(); idle(); #1;
    check("jr2 pc", adr, 32'h200);

    write_reg(5'd0, 32'h1234, 1'b0);
    read_regs(5'd0, 5'd0, av, bv);
    check("r0 rs", av, 32'h0);
    check("r0 rt", bv, 32'h0);
    write_reg(5'd20, 32'h1234, 1'b0);
    read_regs(5'd20, 5'd20, av, bv);
    check("r20 rt", bv, 32'h0);
    write_reg(5'd15, 32'h1234, 1'b0);
    read_regs(5'd15, 5'd15, av, bv);
    check("r15", bv, 32'h1234);

    // Read-during-write: B captures the old r15, the new value appears a cycle later.
    load_ir({6'h23, 5'd15, 5'd15, 16'h0});
    read_data = 32'h5678;
    tick();
    regwrite = 1; memtoreg = 1;
    tick();
    check("rdw old", write_data, 32'h1234);
    idle();
    tick();
    check("rdw new", write_data, 32'h5678);
    model_write(5'd15, 32'h5678);

    write_reg(5'd15, 32'hAAAA_0000, 1'b1);
    read_regs(5'd15, 5'd15, av, bv);
    check("stalled write", bv, 32'h5678);

    for (int it = 0; it < 30; it++) begin
      r = 5'($urandom);
      v = $urandom;
      write_reg(r, v, ($urandom_range(0, 3) == 0));
      rs = 5'($urandom);
      rt = ($urandom_range(0, 1) == 0) ? r : 5'($urandom);
      read_regs(rs, rt, av, bv);
      check($sformatf("rnd%0d r%0d", it, rs), av, model_rf[rs]);
      check($sformatf("rnd%0d r%0d", it, rt), bv, model_rf[rt]);
      op = 3'($urandom);
      alu_check($sformatf("rnd%0d op%b", it, op), rs, rt, op, ref_alu(op, model_rf[rs], model_rf[rt]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
